// File: rtl/serv_trace_ser.sv
// serv_trace_ser
// Serializes one trace record per retired instruction. The records come from the
// CPU's RVFI port and are sent out as bytes over a valid/ready stream.
//
// Each record is 13 bytes, sent in this order:
//   byte 0      header {trap, lost, 1'b0, rd_addr}
//   bytes 1-4   pc, LSB first
//   bytes 5-8   insn, LSB first
//   bytes 9-12  rd_wdata, LSB first
//
// Records are held in a DEPTH-entry FIFO. A record that arrives while the FIFO
// is full is dropped. Each drop bumps the saturating o_drop_cnt and sets a
// sticky "lost" bit. That bit is written into the header of the next record
// that is accepted.
//
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   i_en                    trace enable (gates new retirements only)
//   i_valid                 retirement pulse; i_trap/i_rd_addr/i_pc/i_insn/i_rd_wdata qualify it
//   o_tdata/o_tvalid/o_tlast/i_tready   byte stream, o_tlast on byte 12
//   o_full                  FIFO holds DEPTH records
//   o_drop_cnt              saturating count of dropped records
module serv_trace_ser #(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_valid,
  input  logic              i_trap,
  input  logic [4:0]        i_rd_addr,
  input  logic [31:0]       i_pc,
  input  logic [31:0]       i_insn,
  input  logic [31:0]       i_rd_wdata,
  output logic [7:0]        o_tdata,
  output logic              o_tvalid,
  output logic              o_tlast,
  input  logic              i_tready,
  output logic              o_full,
  output logic [DROP_W-1:0] o_drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int RW = 104;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_t;

  state_t              state_reg, state_next;
  logic [PW-1:0]       wr_ptr_reg, rd_ptr_reg, rd_ptr_inc;
  logic [RW-1:0]       mem [DEPTH];
  logic [RW-1:0]       sr_reg;
  logic [RW-1:0]       wr_rec;
  logic [3:0]          byte_cnt_reg;
  logic                lost_reg;
  logic [DROP_W-1:0]   drop_cnt_reg;

  logic                empty, full;
  logic                hs, pop, push_req, push, drop;
  logic                load;
  logic [AW-1:0]       load_addr;

  // Pack the record so that byte k of the stream sits at bits [8k+7:8k].
  // Shifting right by 8 after each accepted byte then exposes the next byte
  // in sr_reg[7:0].
  assign wr_rec = {i_rd_wdata, i_insn, i_pc, i_trap, lost_reg, 1'b0, i_rd_addr};

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = ((wr_ptr_reg ^ rd_ptr_reg) == {1'b1, {AW{1'b0}}});

  assign o_tvalid   = (state_reg == ST_SEND);
  assign o_tlast    = o_tvalid && (byte_cnt_reg == 4'd12);
  assign o_tdata    = sr_reg[7:0];
  assign o_full     = full;
  assign o_drop_cnt = drop_cnt_reg;

  assign hs         = o_tvalid && i_tready;
  assign pop        = hs && (byte_cnt_reg == 4'd12);
  assign push_req   = i_valid && i_en;
  // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
  assign push       = push_req && (!full || pop);
  assign drop       = push_req && full && !pop;
  assign rd_ptr_inc = rd_ptr_reg + 1'b1;

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    load_addr  = rd_ptr_reg[AW-1:0];
    case (state_reg)
      ST_IDLE: begin
        if (!empty) begin
          load       = 1'b1;
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (pop) begin
          // Read the entry behind the one being popped. A record written in
          // this same cycle is not readable yet, so it is picked up from IDLE.
          if (rd_ptr_inc != wr_ptr_reg) begin
            load      = 1'b1;
            load_addr = rd_ptr_inc[AW-1:0];
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Record storage. It has no reset, so it can map onto RAM.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_rec;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= ST_IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      sr_reg       <= '0;
      byte_cnt_reg <= '0;
      lost_reg     <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;

      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_inc;
      end

      // A push and a drop never occur together, so the priority only matters
      // for readability.
      if (push) begin
        lost_reg <= 1'b0;
      end else if (drop) begin
        lost_reg <= 1'b1;
      end

      if (drop && (drop_cnt_reg != {DROP_W{1'b1}})) begin
        drop_cnt_reg <= drop_cnt_reg + 1'b1;
      end

      // A load takes priority over a shift when the last byte hands off
      // directly to the next record. After the 13th shift sr_reg is all
      // zero, so o_tdata reads 0 in IDLE.
      if (load) begin
        sr_reg       <= mem[load_addr];
        byte_cnt_reg <= '0;
      end else if (hs) begin
        sr_reg       <= {8'h00, sr_reg[RW-1:8]};
        byte_cnt_reg <= byte_cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serv_trace_ser.sv
// Directed testbench for serv_trace_ser (DEPTH=4, DROP_W=8).
// Inputs are driven and outputs are sampled on the falling edge of the clock.
module tb_serv_trace_ser;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_en;
  logic        i_valid;
  logic        i_trap;
  logic [4:0]  i_rd_addr;
  logic [31:0] i_pc;
  logic [31:0] i_insn;
  logic [31:0] i_rd_wdata;
  logic [7:0]  o_tdata;
  logic        o_tvalid;
  logic        o_tlast;
  logic        i_tready;
  logic        o_full;
  logic [7:0]  o_drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  serv_trace_ser #(.DEPTH(4), .DROP_W(8)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_en       (i_en),
    .i_valid    (i_valid),
    .i_trap     (i_trap),
    .i_rd_addr  (i_rd_addr),
    .i_pc       (i_pc),
    .i_insn     (i_insn),
    .i_rd_wdata (i_rd_wdata),
    .o_tdata    (o_tdata),
    .o_tvalid   (o_tvalid),
    .o_tlast    (o_tlast),
    .i_tready   (i_tready),
    .o_full     (o_full),
    .o_drop_cnt (o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Field values for generated record k.
  function automatic logic [31:0] pc_k(input int k);
    return 32'h8000_0000 + 32'(k) * 4;
  endfunction

  task automatic set_fields(input int k);
    i_pc       = pc_k(k);
    i_insn     = 32'h0013_0000 | 32'(k);
    i_rd_wdata = ~pc_k(k) ^ 32'h5a5a_0000;
    i_rd_addr  = 5'(k);
    i_trap     = k[0];
  endtask

  // Expected stream bytes for record k. Byte b of the stream is at bits [8b+7:8b].
  function automatic logic [103:0] exp_k(input int k, input logic lost);
    logic [31:0] pc;
    logic [4:0]  rd;
    pc = pc_k(k);
    rd = 5'(k);
    return {~pc ^ 32'h5a5a_0000, 32'h0013_0000 | 32'(k), pc, k[0], lost, 1'b0, rd};
  endfunction

  task automatic push_k(input int k);
    set_fields(k);
    i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  // Consume nbytes of a record, checking each one. If stall_at is reached,
  // i_tready is held low for stall_len cycles first. With inj set, record
  // inj_k is pushed in the same cycle as the byte-12 handshake.
  task automatic expect_record(input string tag, input logic [103:0] rec, input int stall_at,
                               input int stall_len, input bit inj, input int inj_k, input int nbytes);
    for (int b = 0; b < nbytes; b++) begin
      int guard;
      guard = 0;
      while (o_tvalid !== 1'b1 && guard < 40) begin
        @(negedge i_clk);
        guard++;
      end
      chk($sformatf("%s_tvalid_b%0d", tag, b), o_tvalid, 1);
      if (b == stall_at) begin
        i_tready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge i_clk);
          chk($sformatf("%s_hold_tdata_s%0d", tag, s), o_tdata, rec[8*b +: 8]);
          chk($sformatf("%s_hold_tvalid_s%0d", tag, s), o_tvalid, 1);
        end
        i_tready = 1'b1;
      end
      chk($sformatf("%s_tdata_b%0d", tag, b), o_tdata, rec[8*b +: 8]);
      chk($sformatf("%s_tlast_b%0d", tag, b), o_tlast, (b == 12) ? 1 : 0);
      if (inj && b == 12) begin
        set_fields(inj_k);
        i_valid = 1'b1;
      end
      @(negedge i_clk);
      if (inj && b == 12) i_valid = 1'b0;
    end
  endtask

  logic [7:0]   t1_bytes [13];
  logic [103:0] t1_rec;

  initial begin
    i_rst_n = 1'b0; i_en = 1'b1; i_valid = 1'b0; i_tready = 1'b1;
    i_trap = 1'b0; i_rd_addr = '0; i_pc = '0; i_insn = '0; i_rd_wdata = '0;
    t1_bytes = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                 8'h05, 8'h00, 8'h00, 8'h00};
    for (int b = 0; b < 13; b++) t1_rec[8*b +: 8] = t1_bytes[b];

    // Reset state.
    repeat (2) @(negedge i_clk);
    chk("rst_tvalid", o_tvalid, 0);
    chk("rst_tlast", o_tlast, 0);
    chk("rst_tdata", o_tdata, 0);
    chk("rst_full", o_full, 0);
    chk("rst_drop", o_drop_cnt, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // T1: a single record, with the 2-cycle latency to the first o_tvalid.
    i_pc = 32'h0000_0100; i_insn = 32'h0050_0093; i_rd_addr = 5'd1; i_rd_wdata = 32'd5; i_trap = 1'b0;
    i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    chk("t1_tvalid_lat1", o_tvalid, 0);
    @(negedge i_clk);
    chk("t1_tvalid_lat2", o_tvalid, 1);
    expect_record("t1", t1_rec, -1, 0, 1'b0, 0, 13);
    chk("t1_idle_tvalid", o_tvalid, 0);
    chk("t1_idle_tdata", o_tdata, 0);

    // T2: stall for 5 cycles at byte 3.
    push_k(7);
    expect_record("t2", exp_k(7, 1'b0), 3, 5, 1'b0, 0, 13);
    chk("t2_idle_tvalid", o_tvalid, 0);

    // T3: overflow with the sink stalled, then the lost flag.
    i_tready = 1'b0;
    for (int k = 0; k < 4; k++) push_k(k);
    chk("t3_full_after4", o_full, 1);
    chk("t3_drop_after4", o_drop_cnt, 0);
    push_k(4);
    push_k(5);
    chk("t3_drop_after6", o_drop_cnt, 2);
    i_tready = 1'b1;
    for (int k = 0; k < 4; k++) expect_record($sformatf("t3_r%0d", k), exp_k(k, 1'b0), -1, 0, 1'b0, 0, 13);
    chk("t3_drained_tvalid", o_tvalid, 0);
    chk("t3_drained_full", o_full, 0);
    push_k(8);
    push_k(9);
    expect_record("t3_lost1", exp_k(8, 1'b1), -1, 0, 1'b0, 0, 13);
    expect_record("t3_lost0", exp_k(9, 1'b0), -1, 0, 1'b0, 0, 13);

    // T4: push while full, in the same cycle as the byte-12 handshake.
    i_tready = 1'b0;
    for (int k = 10; k < 14; k++) push_k(k);
    chk("t4_full", o_full, 1);
    i_tready = 1'b1;
    expect_record("t4_r10", exp_k(10, 1'b0), -1, 0, 1'b1, 14, 13);
    chk("t4_drop_unchanged", o_drop_cnt, 2);
    chk("t4_full_after", o_full, 1);
    for (int k = 11; k < 15; k++) expect_record($sformatf("t4_r%0d", k), exp_k(k, 1'b0), -1, 0, 1'b0, 0, 13);
    chk("t4_drained_tvalid", o_tvalid, 0);

    // T5: asynchronous reset in the middle of a record.
    push_k(20);
    expect_record("t5_part", exp_k(20, 1'b0), -1, 0, 1'b0, 0, 6);
    i_rst_n = 1'b0;
    #1;
    chk("t5_rst_tvalid", o_tvalid, 0);
    chk("t5_rst_tdata", o_tdata, 0);
    chk("t5_rst_drop", o_drop_cnt, 0);
    chk("t5_rst_full", o_full, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("t5_post_tvalid", o_tvalid, 0);
    push_k(21);
    chk("t5_lat1", o_tvalid, 0);
    expect_record("t5_r21", exp_k(21, 1'b0), -1, 0, 1'b0, 0, 13);

    // T6: i_en gating, then saturation of the drop counter.
    i_tready = 1'b0;
    for (int k = 30; k < 34; k++) push_k(k);
    chk("t6_full", o_full, 1);
    i_en = 1'b0;
    set_fields(40);
    i_valid = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("t6_en0_drop", o_drop_cnt, 0);
    i_en = 1'b1;
    repeat (254) @(negedge i_clk);
    chk("t6_drop_254", o_drop_cnt, 8'hFE);
    repeat (46) @(negedge i_clk);
    chk("t6_drop_sat", o_drop_cnt, 8'hFF);
    i_valid = 1'b0;
    i_en = 1'b0;
    i_tready = 1'b1;
    for (int k = 30; k < 34; k++) expect_record($sformatf("t6_r%0d", k), exp_k(k, 1'b0), -1, 0, 1'b0, 0, 13);
    chk("t6_drained_tvalid", o_tvalid, 0);
    set_fields(41);
    i_valid = 1'b1;
    repeat (2) @(negedge i_clk);
    i_valid = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("t6_en0_no_push_tvalid", o_tvalid, 0);
    chk("t6_en0_drop_hold", o_drop_cnt, 8'hFF);
    i_en = 1'b1;
    push_k(34);
    expect_record("t6_lost", exp_k(34, 1'b1), -1, 0, 1'b0, 0, 13);
    chk("t6_final_drop", o_drop_cnt, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
